mem_port_arbiter: RTL

//   Shares one single-port byte-addressed memory between the fetch requester (I) and the

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_resp_slot.sv | 33 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } arb_grant_e;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } resp_slot_e;

endpackage

// File: rtl/mem_resp_slot.sv
// One-entry registered response buffer with a valid/ready drain side.
module mem_resp_slot
    import mem_port_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            accept,
    input  logic [XLEN-1:0] accept_data,
    input  logic            resp_ready,
    output logic            can_accept,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data
);

    resp_slot_e state;

    // A slot being drained this cycle may take a new request in the same cycle.
    assign can_accept = (state == SLOT_EMPTY) || resp_ready;
    assign resp_valid = (state == SLOT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SLOT_EMPTY;
            resp_data <= '0;
        end else if (accept) begin
            state     <= SLOT_FULL;
            resp_data <= accept_data;
        end else if (state == SLOT_FULL && resp_ready) begin
            state <= SLOT_EMPTY;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-port memory between the fetch (I) and
// load/store (D) requesters, with a one-entry response buffer per requester.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter bit          I_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    input  logic              i_resp_ready,
    output logic [XLEN-1:0]   i_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [XLEN-1:0]   d_req_wdata,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [XLEN-1:0]   d_resp_data,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    arb_grant_e      grant;
    arb_grant_e      rr_last;
    logic            i_can_accept;
    logic            d_can_accept;
    logic            i_elig;
    logic            d_elig;
    logic [XLEN-1:0] d_accept_data;

    assign i_elig = i_req_valid & i_can_accept;
    assign d_elig = d_req_valid & d_can_accept;

    // Reset gates the grant so no memory write can happen while rst_n is low.
    always_comb begin
        grant = GNT_NONE;
        if (rst_n) begin
            if (i_elig && d_elig) begin
                grant = (rr_last == GNT_I) ? GNT_D : GNT_I;
            end else if (i_elig) begin
                grant = GNT_I;
            end else if (d_elig) begin
                grant = GNT_D;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= I_FIRST ? GNT_D : GNT_I;
        end else if (i_elig && d_elig) begin
            rr_last <= grant;
        end
    end

    assign i_req_ready = (grant == GNT_I);
    assign d_req_ready = (grant == GNT_D);

    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (grant)
            GNT_I: begin
                mem_ren  = 1'b1;
                mem_addr = XLEN'(i_req_addr);
            end
            GNT_D: begin
                mem_ren   = ~d_req_we;
                mem_wen   = d_req_we;
                mem_addr  = XLEN'(d_req_addr);
                mem_wdata = d_req_we ? d_req_wdata : '0;
            end
            default: ;
        endcase
    end

    // Stores are acknowledged with zero data.
    assign d_accept_data = d_req_we ? '0 : mem_rdata;

    mem_resp_slot u_i_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (i_req_ready),
        .accept_data (mem_rdata),
        .resp_ready  (i_resp_ready),
        .can_accept  (i_can_accept),
        .resp_valid  (i_resp_valid),
        .resp_data   (i_resp_data)
    );

    mem_resp_slot u_d_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (d_req_ready),
        .accept_data (d_accept_data),
        .resp_ready  (d_resp_ready),
        .can_accept  (d_can_accept),
        .resp_valid  (d_resp_valid),
        .resp_data   (d_resp_data)
    );

endmodule
